// File: rtl/vga_pg_pkg.sv
// Shared state encoding and default timing for the VGA per-group power-gating sequencer.
package vga_pg_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        ISO    = 2'd1,
        OFF    = 2'd2,
        WAKE   = 2'd3
    } pg_state_e;

    localparam int DEF_NGRP     = 10;
    localparam int DEF_IDLE_CYC = 16;
    localparam int DEF_ISO_CYC  = 2;
    localparam int DEF_WAKE_CYC = 8;
    localparam int DEF_CW       = 8;

endpackage

// File: rtl/vga_pg_grp.sv
// One sensor group's power-gating FSM: idle debounce, isolate, switch off, and arbitrated wake.
//
//   state  | meaning
//   ACTIVE | powered, de-isolated; cnt counts consecutive idle samples
//   ISO    | outputs clamped, switch still closed; cnt times the clamp hold
//   OFF    | clamped and switch open; requests a wake while isg is low
//   WAKE   | switch closed, still clamped; cnt times rail settling
module vga_pg_grp
    import vga_pg_pkg::*;
#(
    parameter int IDLE_CYC = DEF_IDLE_CYC,
    parameter int ISO_CYC  = DEF_ISO_CYC,
    parameter int WAKE_CYC = DEF_WAKE_CYC,
    parameter int CW       = DEF_CW
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      i_isg,
    input  logic      i_grant,
    output pg_state_e o_state,
    output logic      o_iso,
    output logic      o_sleep,
    output logic      o_pwr_ok,
    output logic      o_wake_req
);

    localparam logic [CW-1:0] IDLE_TC = CW'(IDLE_CYC - 1);
    localparam logic [CW-1:0] ISO_TC  = CW'(ISO_CYC - 1);
    localparam logic [CW-1:0] WAKE_TC = CW'(WAKE_CYC - 1);

    pg_state_e     r_state;
    pg_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ACTIVE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ACTIVE: begin
                if (!i_isg) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == IDLE_TC) begin
                    w_state_nxt = ISO;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ISO: begin
                if (!i_isg) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == ISO_TC) begin
                    w_state_nxt = OFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            OFF: begin
                if (i_grant) begin
                    w_state_nxt = WAKE;
                    w_cnt_nxt   = '0;
                end
            end
            WAKE: begin
                // Wake runs to completion whatever isg does meanwhile.
                if (r_cnt == WAKE_TC) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ACTIVE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_state    = r_state;
    assign o_iso      = (r_state != ACTIVE);
    assign o_sleep    = (r_state == OFF);
    assign o_pwr_ok   = (r_state == ACTIVE);
    assign o_wake_req = (r_state == OFF) && !i_isg;

endmodule

// File: rtl/vga_pg_sequencer.sv
// Power-gating sequencer for NGRP sensor groups with a single-waker fixed-priority arbiter.
module vga_pg_sequencer
    import vga_pg_pkg::*;
#(
    parameter int NGRP     = DEF_NGRP,
    parameter int IDLE_CYC = DEF_IDLE_CYC,
    parameter int ISO_CYC  = DEF_ISO_CYC,
    parameter int WAKE_CYC = DEF_WAKE_CYC,
    parameter int CW       = DEF_CW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NGRP-1:0] isg_i,
    output logic [NGRP-1:0] iso_o,
    output logic [NGRP-1:0] sleep_o,
    output logic [NGRP-1:0] pwr_ok_o,
    output logic            busy_o
);

    pg_state_e       w_state [NGRP];
    logic [NGRP-1:0] w_wake_req;
    logic [NGRP-1:0] w_grant;
    logic [NGRP-1:0] w_in_wake;
    logic [NGRP-1:0] w_in_trans;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        vga_pg_grp #(
            .IDLE_CYC (IDLE_CYC),
            .ISO_CYC  (ISO_CYC),
            .WAKE_CYC (WAKE_CYC),
            .CW       (CW)
        ) u_grp (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .i_isg      (isg_i[g]),
            .i_grant    (w_grant[g]),
            .o_state    (w_state[g]),
            .o_iso      (iso_o[g]),
            .o_sleep    (sleep_o[g]),
            .o_pwr_ok   (pwr_ok_o[g]),
            .o_wake_req (w_wake_req[g])
        );

        assign w_in_wake[g]  = (w_state[g] == WAKE);
        assign w_in_trans[g] = (w_state[g] == ISO) || (w_state[g] == WAKE);
    end

    // Lowest set request bit wins; nothing is granted while any group is still waking.
    assign w_grant = (|w_in_wake) ? '0 : (w_wake_req & (~w_wake_req + NGRP'(1)));
    assign busy_o  = |w_in_trans;

endmodule
